reward_txq: RTL and testbench

- Parametrised successor to the single-packet reward stage of the EER-RL node datapath.
- Decodes each received packet (from packetFilter/MY_NODE_INFO/KCH context) into a response packet and applies the Q-value reward update on data packets.
- Computes per-packet TX power setting and post-TX energy, then holds responses in a DEPTH-entry transmit queue drained by okToSend.
- Sits between packetFilter/KCH and the radio TX framer.

---
 rtl/reward_txq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_reward_txq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reward_txq.sv
// Reward stage: turns each received packet into a response entry, applies the Q-value
// reward update on data packets, and buffers responses in a DEPTH-entry transmit queue.
module reward_txq #(
  parameter int unsigned           WORD_WIDTH   = 16,
  parameter int unsigned           DEPTH        = 4,
  parameter int unsigned           ALPHA_SHIFT  = 2,
  parameter logic [WORD_WIDTH-1:0] LOW_E_THRESH = WORD_WIDTH'(16'h1000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2:0]              fPacketType,
  input  logic [WORD_WIDTH-1:0]   fSourceID,
  input  logic [WORD_WIDTH-1:0]   fSourceHops,
  input  logic [WORD_WIDTH-1:0]   fQValue,
  input  logic                    iAmDestination,
  input  logic [WORD_WIDTH-1:0]   myNodeID,
  input  logic [WORD_WIDTH-1:0]   myEnergy,
  input  logic [WORD_WIDTH-1:0]   hopsFromSink,
  input  logic [WORD_WIDTH-1:0]   myQValue,
  input  logic                    role,
  input  logic [WORD_WIDTH-1:0]   chosenCH,
  input  logic [WORD_WIDTH-1:0]   hopsFromCH,
  input  logic                    okToSend,
  output logic                    busy,
  output logic                    rValid,
  output logic [2:0]              rPacketType,
  output logic [WORD_WIDTH-1:0]   rSourceID,
  output logic [WORD_WIDTH-1:0]   rDestinationID,
  output logic [WORD_WIDTH-1:0]   rSourceHops,
  output logic [WORD_WIDTH-1:0]   rHopsFromCH,
  output logic [WORD_WIDTH-1:0]   rQValue,
  output logic [WORD_WIDTH-1:0]   rEnergyLeft,
  output logic [1:0]              tx_setting,
  output logic [WORD_WIDTH-1:0]   qValueOut,
  output logic                    qUpdate,
  output logic                    reward_done,
  output logic                    drop,
  output logic [$clog2(DEPTH):0]  fifoCount,
  output logic                    lowE
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned QW = WORD_WIDTH + 2;
  localparam logic [WORD_WIDTH-1:0] Q_MAX  = WORD_WIDTH'(16'h4000);
  localparam logic [WORD_WIDTH-1:0] COST_0 = WORD_WIDTH'(16'h0005);
  localparam logic [WORD_WIDTH-1:0] COST_1 = WORD_WIDTH'(16'h0009);
  localparam logic [WORD_WIDTH-1:0] COST_2 = WORD_WIDTH'(16'h0011);
  localparam logic [WORD_WIDTH-1:0] COST_3 = WORD_WIDTH'(16'h001B);

  typedef struct packed {
    logic [2:0]            ptype;
    logic [WORD_WIDTH-1:0] f_src;
    logic [WORD_WIDTH-1:0] f_hops;
    logic [WORD_WIDTH-1:0] f_q;
    logic                  i_am_dest;
    logic [WORD_WIDTH-1:0] my_id;
    logic [WORD_WIDTH-1:0] my_energy;
    logic [WORD_WIDTH-1:0] sink_hops;
    logic [WORD_WIDTH-1:0] my_q;
    logic                  role;
    logic [WORD_WIDTH-1:0] ch_id;
    logic [WORD_WIDTH-1:0] ch_hops;
  } rx_t;

  typedef struct packed {
    logic [2:0]            ptype;
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] dst;
    logic [WORD_WIDTH-1:0] src_hops;
    logic [WORD_WIDTH-1:0] dst_hops;
    logic [WORD_WIDTH-1:0] qval;
    logic [WORD_WIDTH-1:0] energy;
    logic [1:0]            tx;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_PUSH = 2'd2} state_t;

  state_t state_q, state_d;
  logic   latch_c, calc_c, push_c;

  rx_t    rx_q;
  entry_t ent_c, ent_q, head_d, head_q;
  logic   enq_c, enq_q, qupd_c, qupd_q;
  logic [WORD_WIDTH-1:0] qnew_c, qnew_q, cost_c;
  logic signed [QW-1:0]  q_diff_c, q_step_c, q_sum_c;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_c, full_c, wr_c, drop_c;

  logic                  busy_q, done_q, qupd_pulse_q, drop_q, lowe_q;
  logic [WORD_WIDTH-1:0] qout_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_CALC;
      S_CALC:  state_d = S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    latch_c = 1'b0;
    calc_c  = 1'b0;
    push_c  = 1'b0;
    case (state_q)
      S_IDLE:  latch_c = en;
      S_CALC:  calc_c  = 1'b1;
      S_PUSH:  push_c  = 1'b1;
      default: ;
    endcase
  end

  // Q update: alpha-weighted step toward the received Q-value, clamped to [0, Q_MAX]
  always_comb begin
    q_diff_c = $signed({2'b00, rx_q.f_q}) - $signed({2'b00, rx_q.my_q});
    q_step_c = q_diff_c >>> ALPHA_SHIFT;
    q_sum_c  = $signed({2'b00, rx_q.my_q}) + q_step_c;
    if (q_sum_c < 0)                             qnew_c = '0;
    else if (q_sum_c > $signed({2'b00, Q_MAX}))  qnew_c = Q_MAX;
    else                                         qnew_c = q_sum_c[WORD_WIDTH-1:0];
  end

  // Response entry built from the latched packet and node context
  always_comb begin
    ent_c  = '0;
    enq_c  = 1'b0;
    qupd_c = 1'b0;
    cost_c = COST_0;
    ent_c.src      = rx_q.my_id;
    ent_c.src_hops = rx_q.sink_hops;
    case (rx_q.ptype)
      3'b000: begin
        enq_c          = 1'b1;
        ent_c.ptype    = 3'b000;
        ent_c.dst      = '1;
        ent_c.dst_hops = WORD_WIDTH'(1);
      end
      3'b010: begin
        enq_c          = ~rx_q.role;
        ent_c.ptype    = 3'b011;
        ent_c.dst      = rx_q.ch_id;
        ent_c.dst_hops = rx_q.ch_hops;
      end
      3'b001: begin
        enq_c          = rx_q.i_am_dest;
        qupd_c         = rx_q.i_am_dest;
        ent_c.ptype    = 3'b001;
        ent_c.src      = rx_q.f_src;
        ent_c.src_hops = rx_q.f_hops;
        ent_c.dst      = rx_q.role ? '0 : rx_q.ch_id;
        ent_c.dst_hops = rx_q.role ? rx_q.sink_hops : rx_q.ch_hops;
      end
      default: ;
    endcase
    ent_c.qval = qupd_c ? qnew_c : rx_q.my_q;
    if (ent_c.dst_hops <= WORD_WIDTH'(1))      ent_c.tx = 2'd0;
    else if (ent_c.dst_hops >= WORD_WIDTH'(4)) ent_c.tx = 2'd3;
    else                                       ent_c.tx = 2'(ent_c.dst_hops - WORD_WIDTH'(1));
    case (ent_c.tx)
      2'd0:    cost_c = COST_0;
      2'd1:    cost_c = COST_1;
      2'd2:    cost_c = COST_2;
      default: cost_c = COST_3;
    endcase
    ent_c.energy = (rx_q.my_energy > cost_c) ? (rx_q.my_energy - cost_c) : '0;
  end

  // Queue control; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    pop_c   = okToSend && (count_q != '0);
    full_c  = (count_q == CW'(DEPTH));
    wr_c    = push_c && enq_q && (!full_c || pop_c);
    drop_c  = push_c && enq_q && full_c && !pop_c;
    rd_d    = pop_c ? rd_q + PW'(1) : rd_q;
    wr_d    = wr_c ? wr_q + PW'(1) : wr_q;
    count_d = count_q + CW'(wr_c) - CW'(pop_c);
    if (count_d == '0)                 head_d = '0;
    else if (wr_c && (wr_q == rd_d))   head_d = ent_q;
    else                               head_d = mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_q] <= ent_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q         <= '0;
      ent_q        <= '0;
      enq_q        <= 1'b0;
      qupd_q       <= 1'b0;
      qnew_q       <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      head_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      qupd_pulse_q <= 1'b0;
      drop_q       <= 1'b0;
      qout_q       <= '0;
      lowe_q       <= 1'b0;
    end else begin
      if (latch_c) begin
        rx_q <= '{ptype: fPacketType, f_src: fSourceID, f_hops: fSourceHops, f_q: fQValue,
                  i_am_dest: iAmDestination, my_id: myNodeID, my_energy: myEnergy,
                  sink_hops: hopsFromSink, my_q: myQValue, role: role,
                  ch_id: chosenCH, ch_hops: hopsFromCH};
      end
      if (calc_c) begin
        ent_q  <= ent_c;
        enq_q  <= enq_c;
        qupd_q <= qupd_c;
        qnew_q <= qnew_c;
      end
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= push_c;
      qupd_pulse_q <= push_c && qupd_q;
      drop_q       <= drop_c;
      if (push_c && qupd_q) qout_q <= qnew_q;
      lowe_q       <= (myEnergy < LOW_E_THRESH);
    end
  end

  assign busy           = busy_q;
  assign rValid         = (count_q != '0);
  assign rPacketType    = head_q.ptype;
  assign rSourceID      = head_q.src;
  assign rDestinationID = head_q.dst;
  assign rSourceHops    = head_q.src_hops;
  assign rHopsFromCH    = head_q.dst_hops;
  assign rQValue        = head_q.qval;
  assign rEnergyLeft    = head_q.energy;
  assign tx_setting     = head_q.tx;
  assign qValueOut      = qout_q;
  assign qUpdate        = qupd_pulse_q;
  assign reward_done    = done_q;
  assign drop           = drop_q;
  assign fifoCount      = count_q;
  assign lowE           = lowe_q;

endmodule

// File: tb/tb_reward_txq.sv
// Scoreboard bench for reward_txq: a packet-level reference model queues expected
// responses; a negedge monitor compares the DUT queue head and pulses against it.
module tb_reward_txq;
  localparam int unsigned W           = 16;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned ALPHA_SHIFT = 2;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, en, iAmDestination, role, okToSend;
  logic [2:0]   fPacketType;
  logic [W-1:0] fSourceID, fSourceHops, fQValue, myNodeID, myEnergy, hopsFromSink, myQValue;
  logic [W-1:0] chosenCH, hopsFromCH;
  logic busy, rValid, qUpdate, reward_done, drop, lowE;
  logic [2:0]   rPacketType;
  logic [W-1:0] rSourceID, rDestinationID, rSourceHops, rHopsFromCH, rQValue, rEnergyLeft, qValueOut;
  logic [1:0]   tx_setting;
  logic [CW-1:0] fifoCount;

  always #5 clk = ~clk;

  reward_txq #(.WORD_WIDTH(W), .DEPTH(DEPTH), .ALPHA_SHIFT(ALPHA_SHIFT), .LOW_E_THRESH(16'h1000)) dut (
    .clk(clk), .rst(rst), .en(en), .fPacketType(fPacketType), .fSourceID(fSourceID),
    .fSourceHops(fSourceHops), .fQValue(fQValue), .iAmDestination(iAmDestination),
    .myNodeID(myNodeID), .myEnergy(myEnergy), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
    .role(role), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .okToSend(okToSend),
    .busy(busy), .rValid(rValid), .rPacketType(rPacketType), .rSourceID(rSourceID),
    .rDestinationID(rDestinationID), .rSourceHops(rSourceHops), .rHopsFromCH(rHopsFromCH),
    .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .tx_setting(tx_setting), .qValueOut(qValueOut),
    .qUpdate(qUpdate), .reward_done(reward_done), .drop(drop), .fifoCount(fifoCount), .lowE(lowE)
  );

  typedef struct {
    int ptype; int src; int dst; int shops; int dhops; int qval; int energy; int tx;
  } resp_t;

  resp_t sb[$];
  int    passed = 0;
  int    total  = 0;
  bit    checking = 1'b0;

  // reference model state
  int    stage = 0;
  resp_t cur;
  bit    cur_enq, cur_qupd;
  int    cur_qv;
  bit    exp_done, exp_qupd, exp_drop, exp_lowe;
  int    exp_qout = 0;
  bit    m_pop, m_full, m_push;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Expected response of one packet, straight from the packet-type rules
  function automatic void ref_resp(output resp_t r, output bit enq, output bit qupd, output int qv);
    int d, step, dh, e;
    int cost_tab [4];
    cost_tab = '{5, 9, 17, 27};
    r = '{default: 0};
    enq = 1'b0;
    qupd = 1'b0;
    d = int'(fQValue) - int'(myQValue);
    if (d >= 0) step = d / (1 << ALPHA_SHIFT);
    else        step = -((-d + (1 << ALPHA_SHIFT) - 1) / (1 << ALPHA_SHIFT));
    qv = int'(myQValue) + step;
    if (qv < 0) qv = 0;
    else if (qv > 'h4000) qv = 'h4000;
    r.src = int'(myNodeID);
    r.shops = int'(hopsFromSink);
    if (fPacketType == 3'd0) begin
      enq = 1'b1; r.ptype = 0; r.dst = 'hFFFF; r.dhops = 1;
    end else if (fPacketType == 3'd2 && !role) begin
      enq = 1'b1; r.ptype = 3; r.dst = int'(chosenCH); r.dhops = int'(hopsFromCH);
    end else if (fPacketType == 3'd1 && iAmDestination) begin
      enq = 1'b1; qupd = 1'b1; r.ptype = 1;
      r.src = int'(fSourceID); r.shops = int'(fSourceHops);
      r.dst = role ? 0 : int'(chosenCH);
      r.dhops = role ? int'(hopsFromSink) : int'(hopsFromCH);
    end
    r.qval = qupd ? qv : int'(myQValue);
    dh = r.dhops;
    if (dh < 1) dh = 1;
    if (dh > 4) dh = 4;
    r.tx = dh - 1;
    e = int'(myEnergy) - cost_tab[r.tx];
    r.energy = (e < 0) ? 0 : e;
  endfunction

  // Reference model: packet acceptance, two-cycle processing, queue with drop/pop rules
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      stage = 0; exp_done = 0; exp_qupd = 0; exp_drop = 0; exp_lowe = 0; exp_qout = 0;
    end else begin
      exp_done = 0; exp_qupd = 0; exp_drop = 0; m_push = 0;
      exp_lowe = (myEnergy < 16'h1000);
      m_pop  = okToSend && (sb.size() > 0);
      m_full = (sb.size() == DEPTH);
      case (stage)
        0: if (en) begin ref_resp(cur, cur_enq, cur_qupd, cur_qv); stage = 1; end
        1: stage = 2;
        default: begin
          stage = 0;
          exp_done = 1;
          if (cur_qupd) begin exp_qupd = 1; exp_qout = cur_qv; end
          if (cur_enq && m_full && !m_pop) exp_drop = 1;
          else m_push = cur_enq;
        end
      endcase
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back(cur);
    end
  end

  // Monitor: compares the DUT's presented head and pulses against the scoreboard
  always @(negedge clk) begin
    resp_t h;
    if (checking) begin
      h = (sb.size() > 0) ? sb[0] : '{default: 0};
      chk("busy", int'(busy), int'(stage != 0));
      chk("reward_done", int'(reward_done), int'(exp_done));
      chk("qUpdate", int'(qUpdate), int'(exp_qupd));
      chk("drop", int'(drop), int'(exp_drop));
      chk("qValueOut", int'(qValueOut), exp_qout);
      chk("lowE", int'(lowE), int'(exp_lowe));
      chk("fifoCount", int'(fifoCount), sb.size());
      chk("rValid", int'(rValid), int'(sb.size() > 0));
      chk("rPacketType", int'(rPacketType), h.ptype);
      chk("rSourceID", int'(rSourceID), h.src);
      chk("rDestinationID", int'(rDestinationID), h.dst);
      chk("rSourceHops", int'(rSourceHops), h.shops);
      chk("rHopsFromCH", int'(rHopsFromCH), h.dhops);
      chk("rQValue", int'(rQValue), h.qval);
      chk("rEnergyLeft", int'(rEnergyLeft), h.energy);
      chk("tx_setting", int'(tx_setting), h.tx);
    end
  end

  // Called at a negedge with inputs set; returns at the negedge after reward_done
  task automatic send(input bit pop_at_push);
    en = 1'b1; @(negedge clk);
    en = 1'b0; @(negedge clk);
    okToSend = pop_at_push; @(negedge clk);
    okToSend = 1'b0;
  endtask

  task automatic pop_n(input int n);
    okToSend = 1'b1; repeat (n) @(negedge clk);
    okToSend = 1'b0;
  endtask

  task automatic rand_fields();
    int t;
    t = $urandom_range(0, 4);
    fPacketType    = (t == 4) ? 3'($urandom_range(3, 7)) : 3'(t % 3);
    fSourceID      = W'($urandom);
    fSourceHops    = W'($urandom_range(0, 9));
    fQValue        = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 'h4000));
    iAmDestination = 1'($urandom_range(0, 1));
    myNodeID       = W'($urandom);
    myEnergy       = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
    hopsFromSink   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom_range(0, 6));
    myQValue       = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 'h4000));
    role           = 1'($urandom_range(0, 1));
    chosenCH       = W'($urandom);
    hopsFromCH     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom_range(0, 6));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; okToSend = 1'b0; iAmDestination = 1'b0; role = 1'b0;
    fPacketType = '0; fSourceID = '0; fSourceHops = '0; fQValue = '0; myNodeID = '0;
    myEnergy = '0; hopsFromSink = '0; myQValue = '0; chosenCH = '0; hopsFromCH = '0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // heartbeat
    fPacketType = 3'd0; myNodeID = 16'd7; myEnergy = 16'h8000; hopsFromSink = 16'd3;
    send(1'b0);
    chk("hb_energy", int'(rEnergyLeft), 'h7FFB);
    chk("hb_dest", int'(rDestinationID), 'hFFFF);
    chk("hb_count", int'(fifoCount), 1);
    pop_n(1);

    // invitation as member, then as cluster head
    fPacketType = 3'd2; role = 1'b0; chosenCH = 16'd23; hopsFromCH = 16'd2; myEnergy = 16'h7FF0;
    send(1'b0);
    chk("inv_type", int'(rPacketType), 3);
    chk("inv_tx", int'(tx_setting), 1);
    chk("inv_energy", int'(rEnergyLeft), 'h7FE7);
    pop_n(1);
    role = 1'b1;
    send(1'b0);
    chk("inv_ch_count", int'(fifoCount), 0);

    // data packet reward updates, the second one clamped
    fPacketType = 3'd1; iAmDestination = 1'b1; role = 1'b0; myQValue = 16'h3555; fQValue = 16'h3000;
    fSourceID = 16'd99; fSourceHops = 16'd5;
    send(1'b0);
    pop_n(1);
    fQValue = 16'hFFFF;
    send(1'b0);
    chk("q_clamp", int'(qValueOut), 'h4000);
    chk("q_fwd", int'(rQValue), 'h4000);
    pop_n(1);
    iAmDestination = 1'b0;
    send(1'b0);

    // fill, overflow, then push+pop while full and drain across the wrap
    fPacketType = 3'd0; myEnergy = 16'h9000;
    for (int i = 0; i < 5; i++) begin
      myNodeID = W'(16'h100 + i);
      send(1'b0);
    end
    chk("full_count", int'(fifoCount), DEPTH);
    myNodeID = 16'h1FF;
    send(1'b1);
    chk("full_pushpop", int'(fifoCount), DEPTH);
    pop_n(DEPTH + 1);

    // energy saturation on a 4-hop destination, with low-energy flag
    fPacketType = 3'd2; role = 1'b0; hopsFromCH = 16'd4; myEnergy = 16'h0003;
    send(1'b0);
    chk("sat_energy", int'(rEnergyLeft), 0);
    chk("sat_tx", int'(tx_setting), 3);
    chk("sat_lowE", int'(lowE), 1);
    pop_n(1);

    // en held while busy produces a single response
    fPacketType = 3'd0; myEnergy = 16'h5000;
    en = 1'b1; repeat (3) @(negedge clk);
    en = 1'b0; @(negedge clk);
    chk("busy_ignore", int'(fifoCount), 1);

    // reset in CALC discards the in-flight packet and the queued entry
    en = 1'b1; @(negedge clk);
    en = 1'b0; rst = 1'b1; @(negedge clk);
    chk("rst_count", int'(fifoCount), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0; @(negedge clk);

    // randomized traffic with random pops and occasional resets
    for (int i = 0; i < 1500; i++) begin
      rand_fields();
      en       = ($urandom_range(0, 3) != 0);
      okToSend = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    en = 1'b0; rst = 1'b0; okToSend = 1'b1;
    repeat (DEPTH + 4) @(negedge clk);
    okToSend = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
